// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment driver: sequential binary-to-BCD conversion,
// leading-zero blanking, overflow dashes and a continuously running digit scan.
module seven_seg_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int VALUE_W     = 32,
  parameter int REFRESH_DIV = 131072,
  parameter int BLANK_LZ    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  output logic               busy,
  output logic [DIGITS-1:0]  AN,
  output logic [6:0]         led
);

  // One spare nibble above both the converter and display widths keeps
  // the overflow test a plain OR over everything above the display.
  localparam int BCD_DIG = (VALUE_W * 30103) / 100000 + 1;
  localparam int BCD_N   = ((BCD_DIG > DIGITS) ? BCD_DIG : DIGITS) + 1;
  localparam int BCD_W   = 4 * BCD_N;
  localparam int DISP_W  = 4 * DIGITS;
  localparam int CNT_W   = $clog2(VALUE_W + 1);
  localparam int PRE_W   = $clog2(REFRESH_DIV);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_W - 1);
  localparam logic [PRE_W-1:0] PRE_TC    = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_TC    = IDX_W'(DIGITS - 1);
  localparam bit               LZ_EN     = (BLANK_LZ != 0);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  logic [VALUE_W-1:0] bin_q;
  logic [VALUE_W-1:0] bin_nxt;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               last_step;
  logic               ovf_nxt;

  logic [DISP_W-1:0]  disp_q;
  logic               ovf_q;

  logic [PRE_W-1:0]   pre_q;
  logic [IDX_W-1:0]   idx_q;

  logic [3:0]         sel_nib;
  logic               sel_zero;
  logic               run_zero;
  logic               blank;
  logic [DIGITS-1:0]  an_nxt;
  logic [6:0]         led_nxt;
  logic [DIGITS-1:0]  an_q;
  logic [6:0]         led_q;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_nxt   = (bcd_adj << 1) | BCD_W'(bin_q[VALUE_W-1]);
    bin_nxt   = bin_q << 1;
    last_step = busy_q && (cnt_q == LAST_STEP);
    ovf_nxt   = |(bcd_nxt >> DISP_W);
  end

  // Display and overflow only change on the final step, so no partial
  // result is ever visible on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (!busy_q) begin
      if (load) begin
        bin_q  <= value;
        bcd_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
    end else begin
      bin_q <= bin_nxt;
      bcd_q <= bcd_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (last_step) begin
        busy_q <= 1'b0;
        disp_q <= bcd_nxt[DISP_W-1:0];
        ovf_q  <= ovf_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_TC) begin
      pre_q <= '0;
      idx_q <= (idx_q == IDX_TC) ? '0 : idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Walk from the MSD down so run_zero means "this and all higher are 0".
  always_comb begin
    sel_nib  = '0;
    sel_zero = 1'b0;
    run_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero & (disp_q[4*i +: 4] == 4'd0);
      if (idx_q == IDX_W'(i)) begin
        sel_nib  = disp_q[4*i +: 4];
        sel_zero = run_zero;
      end
    end
    blank = LZ_EN && (idx_q != '0) && sel_zero;
  end

  always_comb begin
    an_nxt  = ~(DIGITS'(1) << idx_q);
    led_nxt = seg_of(sel_nib);
    if (ovf_q) begin
      led_nxt = SEG_DASH;
    end else if (blank) begin
      led_nxt = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= '1;
      led_q <= SEG_OFF;
    end else begin
      an_q  <= an_nxt;
      led_q <= led_nxt;
    end
  end

  assign busy = busy_q;
  assign AN   = an_q;
  assign led  = led_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: two instances differing only
// in leading-zero blanking, fast refresh so full frames are short.
module tb_seven_seg_scan_driver;

  localparam logic [6:0] BL   = 7'b1111111;
  localparam logic [6:0] DASH = 7'b1111110;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] value = '0;
  logic        busy1, busy0;
  logic [7:0]  an1, an0;
  logic [6:0]  led1, led0;

  int total = 0;
  int bad = 0;

  logic [6:0] seg1 [0:7];
  logic [6:0] seg0 [0:7];
  logic [6:0] e1 [0:7];
  logic [6:0] e0 [0:7];

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .DIGITS(8), .VALUE_W(32), .REFRESH_DIV(4), .BLANK_LZ(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy1), .AN(an1), .led(led1)
  );

  seven_seg_scan_driver #(
    .DIGITS(8), .VALUE_W(32), .REFRESH_DIV(4), .BLANK_LZ(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy0), .AN(an0), .led(led0)
  );

  task automatic capture();
    logic [7:0] sel;
    for (int i = 0; i < 8; i++) begin
      seg1[i] = 7'h55;
      seg0[i] = 7'h55;
    end
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        sel = ~(8'(1) << i);
        if (an1 == sel) seg1[i] = led1;
        if (an0 == sel) seg0[i] = led0;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: busy=%b want=0", busy1);
    end
  endtask

  task automatic do_load(input logic [31:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (an1 !== 8'hFF || led1 !== BL || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: an=%h led=%b busy=%b want an=ff led=1111111 busy=0",
               an1, led1, busy1);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (an1 !== 8'hFE || led1 !== S0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: an=%h led=%b busy=%b want an=fe led=0000001 busy=0",
               an1, led1, busy1);
    end
    total++;
    if (an0 !== 8'hFE || led0 !== S0) begin
      bad++;
      $display("FAIL reset_release_nolz: an=%h led=%b want an=fe led=0000001", an0, led0);
    end
  endtask

  task automatic test_conversion();
    int n = 0;
    wait_idle();
    do_load(32'd12345678);
    while (busy1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL conv_busy_len: got=%0d want=32", n);
    end
    repeat (2) @(negedge clk);
    capture();
    e1 = '{S8, S7, S6, S5, S4, S3, S2, S1};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (seg1[i] !== e1[i]) begin
        bad++;
        $display("FAIL conv_digit%0d: got=%b want=%b", i, seg1[i], e1[i]);
      end
      total++;
      if (seg0[i] !== e1[i]) begin
        bad++;
        $display("FAIL conv_nolz_digit%0d: got=%b want=%b", i, seg0[i], e1[i]);
      end
    end
  endtask

  task automatic test_blanking();
    wait_idle();
    do_load(32'd42);
    wait_idle();
    repeat (2) @(negedge clk);
    capture();
    e1 = '{S2, S4, BL, BL, BL, BL, BL, BL};
    e0 = '{S2, S4, S0, S0, S0, S0, S0, S0};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (seg1[i] !== e1[i]) begin
        bad++;
        $display("FAIL blank_lz_digit%0d: got=%b want=%b", i, seg1[i], e1[i]);
      end
      total++;
      if (seg0[i] !== e0[i]) begin
        bad++;
        $display("FAIL blank_nolz_digit%0d: got=%b want=%b", i, seg0[i], e0[i]);
      end
    end
  endtask

  task automatic test_overflow();
    wait_idle();
    do_load(32'd100000000);
    wait_idle();
    repeat (2) @(negedge clk);
    capture();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (seg1[i] !== DASH || seg0[i] !== DASH) begin
        bad++;
        $display("FAIL ovf_digit%0d: got=%b/%b want=%b", i, seg1[i], seg0[i], DASH);
      end
    end
    do_load(32'd7);
    wait_idle();
    repeat (2) @(negedge clk);
    capture();
    e1 = '{S7, BL, BL, BL, BL, BL, BL, BL};
    e0 = '{S7, S0, S0, S0, S0, S0, S0, S0};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (seg1[i] !== e1[i] || seg0[i] !== e0[i]) begin
        bad++;
        $display("FAIL ovf_recover_digit%0d: got=%b/%b want=%b/%b",
                 i, seg1[i], seg0[i], e1[i], e0[i]);
      end
    end
  endtask

  task automatic test_handshake();
    int hi = 0;
    int fall_m = 0;
    wait_idle();
    do_load(32'd5);
    for (int m = 1; m <= 40; m++) begin
      if (m == 3) begin
        value = 32'd99;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      if (busy1) hi++;
      else if (fall_m == 0) fall_m = m;
      @(negedge clk);
    end
    total++;
    if (hi != 32 || fall_m != 33) begin
      bad++;
      $display("FAIL hs_busy: high=%0d fall=%0d want high=32 fall=33", hi, fall_m);
    end
    capture();
    e1 = '{S5, BL, BL, BL, BL, BL, BL, BL};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (seg1[i] !== e1[i]) begin
        bad++;
        $display("FAIL hs_ignore_digit%0d: got=%b want=%b", i, seg1[i], e1[i]);
      end
    end
    do_load(32'd12345678);
    repeat (10) @(negedge clk);
    rst  = 1'b1;
    load = 1'b1;
    @(negedge clk);
    total++;
    if (busy1 !== 1'b0 || an1 !== 8'hFF) begin
      bad++;
      $display("FAIL hs_rst_mid: busy=%b an=%h want busy=0 an=ff", busy1, an1);
    end
    rst  = 1'b0;
    load = 1'b0;
    @(negedge clk);
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL hs_rst_load: busy=%b want=0", busy1);
    end
    capture();
    e1 = '{S0, BL, BL, BL, BL, BL, BL, BL};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (seg1[i] !== e1[i]) begin
        bad++;
        $display("FAIL hs_rst_digit%0d: got=%b want=%b", i, seg1[i], e1[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    wait_idle();
    do_load(32'd321);
    while (busy1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    value = 32'd90;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    total++;
    if (busy1 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b want=1", busy1);
    end
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL b2b_busy_len: got=%0d want=32", n);
    end
    repeat (2) @(negedge clk);
    capture();
    e1 = '{S0, S9, BL, BL, BL, BL, BL, BL};
    e0 = '{S0, S9, S0, S0, S0, S0, S0, S0};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (seg1[i] !== e1[i] || seg0[i] !== e0[i]) begin
        bad++;
        $display("FAIL b2b_digit%0d: got=%b/%b want=%b/%b",
                 i, seg1[i], seg0[i], e1[i], e0[i]);
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0] prev;
    logic [7:0] exp;
    int n = 0;
    do begin
      prev = an1;
      @(negedge clk);
      n++;
    end while (!(prev == 8'h7F && an1 == 8'hFE) && n < 200);
    total++;
    if (!(prev == 8'h7F && an1 == 8'hFE)) begin
      bad++;
      $display("FAIL scan_wrap: prev=%h an=%h want 7f->fe", prev, an1);
    end
    for (int k = 0; k < 36; k++) begin
      exp = ~(8'(1) << ((k / 4) % 8));
      total++;
      if (an1 !== exp || $countones(~an1) != 1) begin
        bad++;
        $display("FAIL scan_step%0d: an=%h want=%h", k, an1, exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_blanking();
    test_overflow();
    test_handshake();
    test_back_to_back();
    test_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
